traffic_monitor: RTL and testbench
==================================

TRAFFIC_MONITOR -- requirements
Module: traffic_monitor

Interface
REQ-001 The block SHALL have parameter MAX_DWELL, default 16, the maximum number of consecutive cycles any single light pattern may persist (legal range 2..255).
REQ-002 clk  input  1  single system clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 red  input  1  observed red lamp from the traffic controller.
REQ-005 amber  input  1  observed amber lamp.
REQ-006 green  input  1  observed green lamp.
REQ-007 clear  input  1  synchronous clear of error and err_code.
REQ-008 phase  output  3  current tracked phase: 0 SYNC, 1 RED, 2 RED_AMBER, 3 GREEN, 4 AMBER.
REQ-009 error  output  1  sticky flag: a protocol violation has occurred since the last reset or clear.
REQ-010 err_code  output  2  first violation seen: 0 none, 1 ILLEGAL pattern, 2 SEQUENCE, 3 STUCK.
REQ-011 cycles  output  8  count of complete R, RA, G, A, R sequences observed.

Function
REQ-012 Inputs SHALL be sampled as word P={red,amber,green} on each rising edge; all outputs are registered and reflect a sample one cycle after it.
REQ-013 Legal patterns SHALL be 100 RED, 110 RED_AMBER, 001 GREEN and 010 AMBER; 000, 011, 101 and 111 are ILLEGAL.
REQ-014 In SYNC, a legal P SHALL move phase to the matching state with no error; an ILLEGAL P SHALL raise an ILLEGAL error and stay in SYNC.
REQ-015 In a tracked state, P equal to the current phase SHALL hold the state and increment the dwell counter.
REQ-016 In a tracked state, P equal to the successor phase SHALL advance: RED->RED_AMBER->GREEN->AMBER->RED, and reset dwell to 1.
REQ-017 The AMBER->RED transition SHALL increment cycles modulo 256, so 255 wraps to 0.
REQ-018 In a tracked state, a legal P that is neither the current nor the successor phase SHALL raise a SEQUENCE error and move phase to SYNC.
REQ-019 In a tracked state, an ILLEGAL P SHALL raise an ILLEGAL error and move phase to SYNC.
REQ-020 The 8-bit dwell counter SHALL saturate at 255.
REQ-021 When dwell would exceed MAX_DWELL while P is unchanged, the block SHALL raise a STUCK error and move phase to SYNC.
REQ-022 On re-entry from SYNC, the first legal P SHALL resync phase with dwell set to 1.
REQ-023 error SHALL set on the first violation and remain 1; err_code SHALL latch only the first violation, and later violations SHALL not overwrite it.
REQ-024 clear SHALL zero error and err_code on the next edge; a violation in that same cycle SHALL win, setting error=1 and latching the new code.
REQ-025 clear SHALL not affect phase, dwell or cycles.

Reset
REQ-026 While rst_n=0, the outputs SHALL be phase=0, error=0, err_code=0 and cycles=0, with dwell=0, asynchronously.
REQ-027 Deassertion of rst_n SHALL take effect at the next rising edge; the first sampled legal P resyncs per REQ-014.
REQ-028 Reset asserted mid-sequence SHALL discard all tracking with no error and no partial cycle count.

Verification
REQ-029 Reset, then drive 100x3, 110x2, 001x4, 010x2, 100 -> phase reaches 1,2,3,4,1; cycles=1; error=0.
REQ-030 From GREEN, drive 100 -> error=1, err_code=2, phase=0 the next cycle; then drive 010 -> phase=4 with err_code still 2.
REQ-031 Drive 111 during RED -> err_code=1; then drive 000 -> err_code stays 1.
REQ-032 With MAX_DWELL=16, hold 100 for 17 cycles -> err_code=3 on the 17th registered cycle and phase=0.
REQ-033 Complete 256 legal sequences -> cycles wraps to 0, error=0; pulse clear coincident with an illegal pattern -> error=1 and err_code=1.
REQ-034 Assert rst_n=0 asynchronously mid-GREEN -> all outputs zero immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/traffic_monitor.sv
// traffic_monitor: watches a red/amber/green lamp set and flags illegal patterns,
// out-of-order phases and lamps stuck longer than MAX_DWELL cycles.
module traffic_monitor #(
    parameter int unsigned MAX_DWELL = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       red,
    input  logic       amber,
    input  logic       green,
    input  logic       clear,
    output logic [2:0] phase,
    output logic       error,
    output logic [1:0] err_code,
    output logic [7:0] cycles
);
    typedef enum logic [2:0] {SYNC = 3'd0, RED = 3'd1, RED_AMBER = 3'd2, GREEN = 3'd3, AMBER = 3'd4} phase_t;
    localparam logic [1:0] NONE = 2'd0, ILLEGAL = 2'd1, SEQUENCE = 2'd2, STUCK = 2'd3;
    phase_t     state, seen, succ;
    logic [2:0] pat;
    logic [7:0] dwell;
    logic [1:0] viol;
    always_comb begin
        pat  = {red, amber, green};
        seen = pat == 3'b100 ? RED :
               pat == 3'b110 ? RED_AMBER :
               pat == 3'b001 ? GREEN :
               pat == 3'b010 ? AMBER : SYNC;
        succ = state == RED ? RED_AMBER :
               state == RED_AMBER ? GREEN :
               state == GREEN ? AMBER : RED;
        // SYNC accepts any legal pattern; tracked states accept only hold or successor
        viol = seen == SYNC  ? ILLEGAL :
               state == SYNC ? NONE :
               seen == state ? (dwell >= 8'(MAX_DWELL) ? STUCK : NONE) :
               seen == succ  ? NONE : SEQUENCE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SYNC;
            dwell    <= 8'd0;
            cycles   <= 8'd0;
            error    <= 1'b0;
            err_code <= NONE;
        end else begin
            if (viol != NONE) begin
                state <= SYNC;
                dwell <= 8'd0;
            end else if (state == SYNC || seen != state) begin
                state <= seen;
                dwell <= 8'd1;
                if (state == AMBER && seen == RED)
                    cycles <= cycles + 8'd1;
            end else begin
                dwell <= dwell == 8'hff ? 8'hff : dwell + 8'd1;
            end
            // a violation in the same cycle as clear restarts the latch with the new code
            if (viol != NONE) begin
                error    <= 1'b1;
                err_code <= (error && !clear) ? err_code : viol;
            end else if (clear) begin
                error    <= 1'b0;
                err_code <= NONE;
            end
        end
    end
    assign phase = state;
endmodule

// File: tb/tb_traffic_monitor.sv
// tb_traffic_monitor: randomized + directed scoreboard bench for traffic_monitor
// against a pattern-list reference model.
module tb_traffic_monitor;
    localparam int MAXD = 16;
    logic       clk = 1'b0, rst_n = 1'b0, red = 1'b0, amber = 1'b0, green = 1'b0, clear = 1'b0;
    logic [2:0] phase;
    logic       error;
    logic [1:0] err_code;
    logic [7:0] cycles;

    traffic_monitor #(.MAX_DWELL(MAXD)) dut (
        .clk(clk), .rst_n(rst_n), .red(red), .amber(amber), .green(green), .clear(clear),
        .phase(phase), .error(error), .err_code(err_code), .cycles(cycles)
    );

    always #5 clk = ~clk;

    typedef struct {int ph; int er; int cd; int cy;} exp_t;
    exp_t exp_q[$];
    int checks = 0, errors = 0;

    // reference model: index into the legal order R,RA,G,A (-1 = not tracking)
    logic [2:0] pats [4] = '{3'b100, 3'b110, 3'b001, 3'b010};
    int m_ti, m_dw, m_err, m_code, m_cyc;

    task automatic model_reset();
        m_ti = -1; m_dw = 0; m_err = 0; m_code = 0; m_cyc = 0;
    endtask

    task automatic model_step(input logic [2:0] p, input logic clr);
        int idx = -1;
        int v = 0;
        for (int i = 0; i < 4; i++) if (pats[i] == p) idx = i;
        if (idx < 0) v = 1;
        else if (m_ti >= 0) begin
            if (idx == m_ti) begin
                if (m_dw + 1 > MAXD) v = 3;
            end else if (idx != (m_ti + 1) % 4) v = 2;
        end
        if (v != 0) begin
            m_ti = -1; m_dw = 0;
        end else if (m_ti < 0 || idx != m_ti) begin
            if (m_ti == 3 && idx == 0) m_cyc = (m_cyc + 1) % 256;
            m_ti = idx; m_dw = 1;
        end else m_dw = (m_dw + 1 > 255) ? 255 : m_dw + 1;
        if (v != 0) begin
            if (!(m_err == 1 && !clr)) m_code = v;
            m_err = 1;
        end else if (clr) begin
            m_err = 0; m_code = 0;
        end
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, want);
        end
    endtask

    task automatic drive(input logic [2:0] p, input logic c);
        exp_t e;
        @(negedge clk);
        {red, amber, green} = p;
        clear = c;
        model_step(p, c);
        e.ph = m_ti + 1; e.er = m_err; e.cd = m_code; e.cy = m_cyc;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_phase", int'(phase), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_code", int'(err_code), 0);
        chk("rst_cycles", int'(cycles), 0);
        @(posedge clk);
        #2;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("phase", int'(phase), e.ph);
                chk("error", int'(error), e.er);
                chk("err_code", int'(err_code), e.cd);
                chk("cycles", int'(cycles), e.cy);
            end
        end
    end

    initial begin
        int r, k;
        logic [2:0] p;
        model_reset();
        do_reset();
        // full sequence with varied dwell
        repeat (3) drive(3'b100, 0);
        repeat (2) drive(3'b110, 0);
        repeat (4) drive(3'b001, 0);
        repeat (2) drive(3'b010, 0);
        drive(3'b100, 0);
        after_edge();
        chk("seq_phase", int'(phase), 1);
        chk("seq_cycles", int'(cycles), 1);
        chk("seq_error", int'(error), 0);
        // sequence error from GREEN, then resync keeps first code
        drive(3'b110, 0); drive(3'b001, 0); drive(3'b100, 0);
        after_edge();
        chk("seqerr_code", int'(err_code), 2);
        chk("seqerr_phase", int'(phase), 0);
        drive(3'b010, 0);
        after_edge();
        chk("resync_phase", int'(phase), 4);
        chk("resync_code", int'(err_code), 2);
        // illegal during RED, second violation does not overwrite
        do_reset();
        drive(3'b100, 0); drive(3'b111, 0);
        after_edge();
        chk("illegal_code", int'(err_code), 1);
        drive(3'b000, 0);
        after_edge();
        chk("sticky_code", int'(err_code), 1);
        // clear with legal pattern clears; clear with violation latches new code
        drive(3'b100, 1);
        after_edge();
        chk("clear_error", int'(error), 0);
        drive(3'b100, 0); drive(3'b111, 0); drive(3'b100, 0); drive(3'b001, 1);
        after_edge();
        chk("clear_viol_code", int'(err_code), 2);
        // stuck: 16 holds are fine, the 17th trips
        do_reset();
        repeat (16) drive(3'b100, 0);
        after_edge();
        chk("dwell16_error", int'(error), 0);
        drive(3'b100, 0);
        after_edge();
        chk("stuck_code", int'(err_code), 3);
        chk("stuck_phase", int'(phase), 0);
        // cycle counter wrap
        do_reset();
        for (int i = 0; i < 256; i++) begin
            drive(3'b100, 0); drive(3'b110, 0); drive(3'b001, 0); drive(3'b010, 0);
        end
        drive(3'b100, 0);
        after_edge();
        chk("wrap_cycles", int'(cycles), 0);
        chk("wrap_error", int'(error), 0);
        drive(3'b111, 1);
        after_edge();
        chk("clr_ill_error", int'(error), 1);
        chk("clr_ill_code", int'(err_code), 1);
        // async reset mid-GREEN
        drive(3'b100, 0); drive(3'b110, 0); drive(3'b001, 0);
        do_reset();
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            k = (m_ti < 0) ? $urandom_range(0, 3) :
                (r < 55) ? m_ti :
                (r < 88) ? (m_ti + 1) % 4 : $urandom_range(0, 3);
            p = pats[k];
            if (r >= 95) p = 3'($urandom_range(0, 7));
            drive(p, $urandom_range(0, 19) == 0);
        end
        drive(3'b100, 0);
        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
